// File: rtl/brqrv_mem_pkg.sv
// Shared types and widths for the SRAM arbiter slice.
// No logic; types only.
// No flow control here; see the arbiter and its interface.
package brqrv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_WB   = 1'b0,
        OWN_CORE = 1'b1
    } owner_e;

    localparam int SRAM_DW = 32;
    localparam int SRAM_MW = 4;

    // One-hot grant bit positions
    localparam int GNT_WB_BIT   = 0;
    localparam int GNT_CORE_BIT = 1;

endpackage

// File: rtl/brqrv_sram_arbiter_if.sv
// Bundles the Wishbone slave, core data port and SRAM macro pins.
// Latency: none (wires only).
// Backpressure: Wishbone holds stb until ack; core holds req until gnt.
interface brqrv_sram_arbiter_if #(
    parameter int ADDR_W = 8
);
    import brqrv_mem_pkg::*;

    // Wishbone slave side
    logic               wbs_cyc_i;
    logic               wbs_stb_i;
    logic               wbs_we_i;
    logic [SRAM_MW-1:0] wbs_sel_i;
    logic [31:0]        wbs_adr_i;
    logic [SRAM_DW-1:0] wbs_dat_i;
    logic               wbs_ack_o;
    logic [SRAM_DW-1:0] wbs_dat_o;

    // Core data port
    logic               core_req_i;
    logic               core_we_i;
    logic [SRAM_MW-1:0] core_wstrb_i;
    logic [ADDR_W-1:0]  core_addr_i;
    logic [SRAM_DW-1:0] core_wdata_i;
    logic               core_gnt_o;
    logic               core_rvalid_o;
    logic [SRAM_DW-1:0] core_rdata_o;

    // SRAM macro side
    logic               sram_csb_o;
    logic               sram_web_o;
    logic [SRAM_MW-1:0] sram_wmask_o;
    logic [ADDR_W-1:0]  sram_addr_o;
    logic [SRAM_DW-1:0] sram_din_o;
    logic [SRAM_DW-1:0] sram_dout_i;

    // Arbiter view
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  core_req_i, core_we_i, core_wstrb_i, core_addr_i, core_wdata_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        output sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o,
        input  sram_dout_i
    );

    // Requesters + macro view
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output core_req_i, core_we_i, core_wstrb_i, core_addr_i, core_wdata_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        input  sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o,
        output sram_dout_i
    );

endinterface

// File: rtl/brqrv_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, previous owner loses ties.
// Latency: combinational.
// Backpressure: grants nothing while i_en is low.
module brqrv_rr_arb2
    import brqrv_mem_pkg::*;
(
    input  logic       i_en,
    input  logic       i_req_wb,
    input  logic       i_req_core,
    input  owner_e     i_last_owner,
    output logic [1:0] o_gnt
);

    // Single requester wins outright; on a tie the one that did not go last wins
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req_wb && i_req_core) begin
                if (i_last_owner == OWN_WB) begin
                    o_gnt[GNT_CORE_BIT] = 1'b1;
                end else begin
                    o_gnt[GNT_WB_BIT] = 1'b1;
                end
            end else if (i_req_wb) begin
                o_gnt[GNT_WB_BIT] = 1'b1;
            end else if (i_req_core) begin
                o_gnt[GNT_CORE_BIT] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/brqrv_sram_arbiter.sv
// Shares one single-port SRAM between the Wishbone slave bus and the core.
// Latency: request seen in IDLE cycle N, ack/rvalid in N+2, next arbitration N+3.
// Backpressure: loser keeps requesting; core gets gnt only in a winning IDLE cycle.
module brqrv_sram_arbiter
    import brqrv_mem_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                boot_mode_i,
    brqrv_sram_arbiter_if.slave bus
);

    logic               w_wb_req;
    logic               w_core_rq;
    logic               w_idle;
    logic [1:0]         w_gnt;
    logic               w_unused;

    state_e             r_state;
    owner_e             r_owner;
    owner_e             r_last_owner;
    logic               r_we;
    logic               r_csb;
    logic               r_web;
    logic [SRAM_MW-1:0] r_wmask;
    logic [ADDR_W-1:0]  r_addr;
    logic [SRAM_DW-1:0] r_din;
    logic               r_wb_ack;
    logic               r_core_rvalid;

    // Only the word-address and window bits matter; byte offset is ignored
    assign w_unused  = ^bus.wbs_adr_i[1:0];

    assign w_wb_req  = bus.wbs_cyc_i && bus.wbs_stb_i &&
                       (bus.wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign w_core_rq = bus.core_req_i && !boot_mode_i;
    assign w_idle    = (r_state == IDLE);

    brqrv_rr_arb2 u_arb (
        .i_en         (w_idle),
        .i_req_wb     (w_wb_req),
        .i_req_core   (w_core_rq),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_gnt)
    );

    // IDLE -> ACCESS -> RESP -> IDLE; SRAM controls and response strobes are registered
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state       <= IDLE;
            r_owner       <= OWN_CORE;
            r_last_owner  <= OWN_CORE;
            r_we          <= 1'b0;
            r_csb         <= 1'b1;
            r_web         <= 1'b1;
            r_wmask       <= '0;
            r_addr        <= '0;
            r_din         <= '0;
            r_wb_ack      <= 1'b0;
            r_core_rvalid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt[GNT_WB_BIT]) begin
                        r_state      <= ACCESS;
                        r_owner      <= OWN_WB;
                        r_last_owner <= OWN_WB;
                        r_we         <= bus.wbs_we_i;
                        r_csb        <= 1'b0;
                        r_web        <= !bus.wbs_we_i;
                        r_wmask      <= bus.wbs_we_i ? bus.wbs_sel_i : '0;
                        r_addr       <= bus.wbs_adr_i[ADDR_W+1:2];
                        r_din        <= bus.wbs_dat_i;
                    end else if (w_gnt[GNT_CORE_BIT]) begin
                        r_state      <= ACCESS;
                        r_owner      <= OWN_CORE;
                        r_last_owner <= OWN_CORE;
                        r_we         <= bus.core_we_i;
                        r_csb        <= 1'b0;
                        r_web        <= !bus.core_we_i;
                        r_wmask      <= bus.core_we_i ? bus.core_wstrb_i : '0;
                        r_addr       <= bus.core_addr_i;
                        r_din        <= bus.core_wdata_i;
                    end
                end
                ACCESS: begin
                    // Macro samples at this edge; release it and raise the response strobe
                    r_state       <= RESP;
                    r_csb         <= 1'b1;
                    r_web         <= 1'b1;
                    r_wmask       <= '0;
                    r_addr        <= '0;
                    r_din         <= '0;
                    r_wb_ack      <= (r_owner == OWN_WB);
                    r_core_rvalid <= (r_owner == OWN_CORE);
                end
                RESP: begin
                    r_state       <= IDLE;
                    r_wb_ack      <= 1'b0;
                    r_core_rvalid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sram_csb_o    = r_csb;
    assign bus.sram_web_o    = r_web;
    assign bus.sram_wmask_o  = r_wmask;
    assign bus.sram_addr_o   = r_addr;
    assign bus.sram_din_o    = r_din;

    // Macro dout only becomes valid in RESP, so read data is steered straight through
    assign bus.wbs_ack_o     = r_wb_ack;
    assign bus.wbs_dat_o     = (r_wb_ack && !r_we) ? bus.sram_dout_i : '0;
    assign bus.core_gnt_o    = w_gnt[GNT_CORE_BIT];
    assign bus.core_rvalid_o = r_core_rvalid;
    assign bus.core_rdata_o  = (r_core_rvalid && !r_we) ? bus.sram_dout_i : '0;

endmodule

// File: tb/tb_brqrv_sram_arbiter.sv
// Directed bench for the SRAM arbiter with a behavioural 1-cycle-read SRAM.
// Latency: checks N+2 ack/rvalid timing and round-robin spacing.
// Backpressure: requesters hold until ack/gnt; every wait is cycle-bounded.
module tb_brqrv_sram_arbiter;
    import brqrv_mem_pkg::*;

    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic boot;

    int checks = 0;
    int errors = 0;
    int gnt_cnt = 0;
    int rvalid_cnt = 0;

    logic [31:0] mem [0:255];

    brqrv_sram_arbiter_if #(.ADDR_W(ADDR_W)) bus_if ();

    brqrv_sram_arbiter #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (32'h3000_0000)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .boot_mode_i (boot),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    // SRAM macro model: masked write or registered read when selected
    always @(posedge clk) begin : sram_model
        logic [31:0] nw;
        if (!bus_if.sram_csb_o) begin
            if (!bus_if.sram_web_o) begin
                nw = mem[bus_if.sram_addr_o];
                for (int b = 0; b < 4; b++)
                    if (bus_if.sram_wmask_o[b]) nw[8*b +: 8] = bus_if.sram_din_o[8*b +: 8];
                mem[bus_if.sram_addr_o] <= nw;
            end else begin
                bus_if.sram_dout_i <= mem[bus_if.sram_addr_o];
            end
        end
    end

    // Count core-side strobes for lock-out and abandoned-transaction checks
    always @(negedge clk) begin
        if (bus_if.core_gnt_o)    gnt_cnt++;
        if (bus_if.core_rvalid_o) rvalid_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus_if.wbs_cyc_i    = 1'b0;
        bus_if.wbs_stb_i    = 1'b0;
        bus_if.wbs_we_i     = 1'b0;
        bus_if.wbs_sel_i    = 4'h0;
        bus_if.wbs_adr_i    = 32'h0;
        bus_if.wbs_dat_i    = 32'h0;
        bus_if.core_req_i   = 1'b0;
        bus_if.core_we_i    = 1'b0;
        bus_if.core_wstrb_i = 4'h0;
        bus_if.core_addr_i  = '0;
        bus_if.core_wdata_i = 32'h0;
    endtask

    // Stimulus only: one Wishbone access, returns ack cycle offset (-1 on timeout)
    task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        bus_if.wbs_cyc_i = 1'b1;
        bus_if.wbs_stb_i = 1'b1;
        bus_if.wbs_we_i  = we;
        bus_if.wbs_sel_i = sel;
        bus_if.wbs_adr_i = adr;
        bus_if.wbs_dat_i = dat;
        lat = -1;
        rd  = 32'h0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_if.wbs_ack_o) begin
                lat = c;
                rd  = bus_if.wbs_dat_o;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus_if.wbs_cyc_i = 1'b0;
        bus_if.wbs_stb_i = 1'b0;
        bus_if.wbs_we_i  = 1'b0;
    endtask

    // Stimulus only: one core access, returns grant and rvalid cycle offsets
    task automatic core_xfer(input logic we, input logic [3:0] strb, input logic [7:0] addr,
                             input logic [31:0] dat, output logic [31:0] rd,
                             output int gl, output int rl);
        @(posedge clk); #1;
        bus_if.core_req_i   = 1'b1;
        bus_if.core_we_i    = we;
        bus_if.core_wstrb_i = strb;
        bus_if.core_addr_i  = addr;
        bus_if.core_wdata_i = dat;
        gl = -1;
        rl = -1;
        rd = 32'h0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_if.core_gnt_o && gl < 0) gl = c;
            if (bus_if.core_rvalid_o) begin
                rl = c;
                rd = bus_if.core_rdata_o;
                break;
            end
            @(posedge clk); #1;
            if (gl >= 0) bus_if.core_req_i = 1'b0;
        end
        @(posedge clk); #1;
        bus_if.core_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        boot  = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_if.sram_csb_o, bus_if.sram_web_o, bus_if.sram_wmask_o, bus_if.sram_addr_o, bus_if.sram_din_o}
            !== {1'b1, 1'b1, 4'h0, 8'h00, 32'h0}) begin
            errors++;
            $display("FAIL reset_sram got csb=%b web=%b wmask=%h addr=%h din=%h exp 1 1 0 00 00000000",
                     bus_if.sram_csb_o, bus_if.sram_web_o, bus_if.sram_wmask_o, bus_if.sram_addr_o, bus_if.sram_din_o);
        end
        checks++;
        if ({bus_if.wbs_ack_o, bus_if.wbs_dat_o, bus_if.core_gnt_o, bus_if.core_rvalid_o, bus_if.core_rdata_o}
            !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_resp got ack=%b dat=%h gnt=%b rvalid=%b rdata=%h exp all 0",
                     bus_if.wbs_ack_o, bus_if.wbs_dat_o, bus_if.core_gnt_o, bus_if.core_rvalid_o, bus_if.core_rdata_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_if.sram_csb_o, bus_if.wbs_ack_o, bus_if.core_rvalid_o} !== 3'b100) begin
                errors++;
                $display("FAIL idle_cycle%0d got csb=%b ack=%b rvalid=%b exp 1 0 0", c,
                         bus_if.sram_csb_o, bus_if.wbs_ack_o, bus_if.core_rvalid_o);
            end
        end
    endtask

    task automatic test_wb_write_read();
        logic [31:0] rd;
        int lat, gl, rl;
        @(posedge clk); #1;
        bus_if.wbs_cyc_i = 1'b1;
        bus_if.wbs_stb_i = 1'b1;
        bus_if.wbs_we_i  = 1'b1;
        bus_if.wbs_sel_i = 4'hF;
        bus_if.wbs_adr_i = 32'h3000_0010;
        bus_if.wbs_dat_i = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (bus_if.sram_csb_o !== 1'b1) begin
            errors++;
            $display("FAIL wr_win_cycle_csb got %b exp 1", bus_if.sram_csb_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus_if.sram_csb_o, bus_if.sram_web_o, bus_if.sram_wmask_o, bus_if.sram_addr_o, bus_if.sram_din_o}
            !== {1'b0, 1'b0, 4'hF, 8'h04, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL wr_access got csb=%b web=%b wmask=%h addr=%h din=%h exp 0 0 f 04 deadbeef",
                     bus_if.sram_csb_o, bus_if.sram_web_o, bus_if.sram_wmask_o, bus_if.sram_addr_o, bus_if.sram_din_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus_if.wbs_ack_o, bus_if.wbs_dat_o, bus_if.sram_csb_o} !== {1'b1, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL wr_ack got ack=%b dat=%h csb=%b exp 1 00000000 1",
                     bus_if.wbs_ack_o, bus_if.wbs_dat_o, bus_if.sram_csb_o);
        end
        @(posedge clk); #1;
        bus_if.wbs_cyc_i = 1'b0;
        bus_if.wbs_stb_i = 1'b0;
        bus_if.wbs_we_i  = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.wbs_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack_single_pulse got %b exp 0", bus_if.wbs_ack_o);
        end
        wb_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0, rd, lat);
        checks++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wb_read got lat=%0d data=%h exp lat=2 data=deadbeef", lat, rd);
        end
        core_xfer(1'b0, 4'h0, 8'h04, 32'h0, rd, gl, rl);
        checks++;
        if (gl !== 0 || rl !== 2 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL core_read got gnt=%0d rvalid=%0d data=%h exp 0 2 deadbeef", gl, rl, rd);
        end
        // Last word of the window, written by Wishbone and read back by the core
        wb_xfer(1'b1, 4'hF, 32'h3000_03FC, 32'hA5A5_5A5A, rd, lat);
        core_xfer(1'b0, 4'h0, 8'hFF, 32'h0, rd, gl, rl);
        checks++;
        if (lat !== 2 || rl !== 2 || rd !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL top_word got wlat=%0d rlat=%0d data=%h exp 2 2 a5a55a5a", lat, rl, rd);
        end
    endtask

    task automatic test_round_robin();
        logic eg, ea, er;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_if.wbs_cyc_i   = 1'b1;
        bus_if.wbs_stb_i   = 1'b1;
        bus_if.wbs_we_i    = 1'b0;
        bus_if.wbs_sel_i   = 4'hF;
        bus_if.wbs_adr_i   = 32'h3000_0010;
        bus_if.core_req_i  = 1'b1;
        bus_if.core_we_i   = 1'b0;
        bus_if.core_addr_i = 8'hFF;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            eg = (c == 3 || c == 9);
            ea = (c == 2 || c == 8);
            er = (c == 5 || c == 11);
            checks++;
            if ({bus_if.core_gnt_o, bus_if.wbs_ack_o, bus_if.core_rvalid_o} !== {eg, ea, er}) begin
                errors++;
                $display("FAIL rr_cycle%0d got gnt=%b ack=%b rvalid=%b exp %b %b %b", c,
                         bus_if.core_gnt_o, bus_if.wbs_ack_o, bus_if.core_rvalid_o, eg, ea, er);
            end
            if (c == 2) begin
                checks++;
                if (bus_if.wbs_dat_o !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL rr_wb_data got %h exp deadbeef", bus_if.wbs_dat_o);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus_if.core_rdata_o !== 32'hA5A5_5A5A) begin
                    errors++;
                    $display("FAIL rr_core_data got %h exp a5a55a5a", bus_if.core_rdata_o);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_boot_mode();
        logic [31:0] rd;
        int lat, g0, r0;
        @(posedge clk); #1;
        g0 = gnt_cnt;
        r0 = rvalid_cnt;
        boot = 1'b1;
        bus_if.core_req_i  = 1'b1;
        bus_if.core_addr_i = 8'h04;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (gnt_cnt !== g0) begin
            errors++;
            $display("FAIL boot_no_gnt got %0d grants exp 0", gnt_cnt - g0);
        end
        wb_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0, rd, lat);
        checks++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL boot_wb_read got lat=%0d data=%h exp 2 deadbeef", lat, rd);
        end
        checks++;
        if (gnt_cnt !== g0 || rvalid_cnt !== r0) begin
            errors++;
            $display("FAIL boot_core_quiet got gnt=%0d rvalid=%0d exp 0 0", gnt_cnt - g0, rvalid_cnt - r0);
        end
        bus_if.core_req_i = 1'b0;
        boot = 1'b0;
    endtask

    task automatic test_miss_and_bytes();
        logic [31:0] rd;
        int lat;
        @(posedge clk); #1;
        bus_if.wbs_cyc_i = 1'b1;
        bus_if.wbs_stb_i = 1'b1;
        bus_if.wbs_we_i  = 1'b0;
        bus_if.wbs_adr_i = 32'h3000_0400;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_if.wbs_ack_o, bus_if.sram_csb_o} !== 2'b01) begin
                errors++;
                $display("FAIL miss_cycle%0d got ack=%b csb=%b exp 0 1", c, bus_if.wbs_ack_o, bus_if.sram_csb_o);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        wb_xfer(1'b1, 4'hF, 32'h3000_0000, 32'h1122_3344, rd, lat);
        wb_xfer(1'b1, 4'b0010, 32'h3000_0000, 32'h0000_AB00, rd, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL byte_write_lat got %0d exp 2", lat);
        end
        wb_xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h1122_AB44) begin
            errors++;
            $display("FAIL byte_readback got %h exp 1122ab44", rd);
        end
        wb_xfer(1'b1, 4'h0, 32'h3000_0000, 32'hFFFF_FFFF, rd, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL zero_mask_lat got %0d exp 2", lat);
        end
        wb_xfer(1'b0, 4'hF, 32'h3000_0000, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h1122_AB44) begin
            errors++;
            $display("FAIL zero_mask_readback got %h exp 1122ab44", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, r0;
        r0 = rvalid_cnt;
        @(posedge clk); #1;
        bus_if.core_req_i  = 1'b1;
        bus_if.core_we_i   = 1'b0;
        bus_if.core_addr_i = 8'h04;
        @(negedge clk);
        checks++;
        if (bus_if.core_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_gnt got %b exp 1", bus_if.core_gnt_o);
        end
        @(posedge clk); #1;
        bus_if.core_req_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.sram_csb_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_access got csb=%b exp 0", bus_if.sram_csb_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_if.sram_csb_o, bus_if.core_rvalid_o} !== 2'b10) begin
            errors++;
            $display("FAIL mid_after_reset got csb=%b rvalid=%b exp 1 0", bus_if.sram_csb_o, bus_if.core_rvalid_o);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (rvalid_cnt !== r0) begin
            errors++;
            $display("FAIL mid_no_rvalid got %0d pulses exp 0", rvalid_cnt - r0);
        end
        wb_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0, rd, lat);
        checks++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mid_next_wb got lat=%0d data=%h exp 2 deadbeef", lat, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus_if.sram_dout_i = 32'h0;
        test_reset();
        test_wb_write_read();
        test_round_robin();
        test_boot_mode();
        test_miss_and_bytes();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
